mac_accum_16: RTL and testbench

Sequential multiply-accumulate stage directly downstream of the 16x16 combinational multiplier. Accepts a programmed number of unsigned 16-bit operand pairs over a valid/ready stream, multiplies each pair, and sums the 32-bit products into a wide accumulator. Returns one result per run on a valid/ready output. Feeds the detector's feature/energy computation with dot products and sums of squares.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_accum_16_mult.sv | 14 +
 rtl/mac_accum_16.sv | 138 +++++++++++++
 tb/tb_mac_accum_16.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate stage: FSM states,
// default widths and the operand-pair payload.
package mac_pkg;

  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned LEN_W_DEF = 16;
  localparam int unsigned OP_W      = 16;
  localparam int unsigned PROD_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mac_accum_16_mult.sv
// Combinational 16x16 unsigned multiplier feeding the product register.
//   a, b    : unsigned 16-bit operands
//   prod_c  : full 32-bit product (combinational)
module mult_16x16_Ca
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod_c
);

  assign prod_c = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_accum_16.sv
// Sequential multiply-accumulate stage. Takes a programmed number of
// unsigned 16-bit operand pairs over a valid/ready stream, multiplies each
// pair and sums the products into an ACC_W-bit accumulator, returning one
// result per run over a valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, len          : begin a run of len pairs (sampled in IDLE only)
//   in_valid/in_ready   : operand stream handshake, in_a/in_b operands
//   out_valid/out_ready : result handshake, out_acc result
//   ovf                 : sticky carry-out of the accumulator for this run
//   busy                : high whenever the FSM is not IDLE
module mac_accum_16
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned SUM_W = ACC_W + 1;

  state_t             state_q, state_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic [LEN_W-1:0]   cnt_q, cnt_nxt;
  logic               clear_c;
  logic               accept_c;

  op_pair_t           op_q;
  logic               s1_valid_q;
  logic [PROD_W-1:0]  prod_c;
  logic [PROD_W-1:0]  prod_q;
  logic               s2_valid_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [SUM_W-1:0]   sum_c;

  assign accept_c = in_valid & in_ready;

  // Next-state, run-length latch and issue counter
  always_comb begin
    state_nxt = state_q;
    len_nxt   = len_q;
    cnt_nxt   = cnt_q;
    clear_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_c   = 1'b1;
          len_nxt   = len;
          cnt_nxt   = '0;
          state_nxt = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) cnt_nxt = cnt_q + LEN_W'(1);
        if (cnt_q == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; handshake/status outputs are registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      len_q     <= len_nxt;
      cnt_q     <= cnt_nxt;
      in_ready  <= (state_nxt == ACCUM) && (cnt_nxt != len_nxt);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  mult_16x16_Ca u_mult (
    .a      (op_q.a),
    .b      (op_q.b),
    .prod_c (prod_c)
  );

  // Extra top bit captures the carry-out of the accumulate
  assign sum_c = {1'b0, acc_q} + SUM_W'(prod_q);

  // Three-stage datapath: operands, product, accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        op_q.a <= in_a;
        op_q.b <= in_b;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) prod_q <= prod_c;
      if (clear_c) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (s2_valid_q) begin
        acc_q <= sum_c[ACC_W-1:0];
        if (sum_c[ACC_W]) ovf_q <= 1'b1;
      end
    end
  end

  assign out_acc = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_accum_16.sv
// Bench for mac_accum_16: two instances (40-bit and 32-bit accumulator)
// share one stimulus stream; each result is compared against the plain
// arithmetic sum of accepted products reduced modulo 2^ACC_W.
module tb_mac_accum_16;

  localparam longint unsigned M40 = 64'h0000_00FF_FFFF_FFFF;
  localparam longint unsigned M32 = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, ovf_w, busy_w;
  logic [39:0] out_acc_w;
  logic        in_ready_n, out_valid_n, ovf_n, busy_n;
  logic [31:0] out_acc_n;

  always #5 clk = ~clk;

  mac_accum_16 #(.ACC_W(40), .LEN_W(16)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_acc(out_acc_w),
    .ovf(ovf_w), .busy(busy_w)
  );

  mac_accum_16 #(.ACC_W(32), .LEN_W(16)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_acc(out_acc_n),
    .ovf(ovf_n), .busy(busy_n)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] pa [16];
  logic [15:0] pb [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_rdy, input logic e_vld, input logic e_busy);
    chk({tag, ".in_ready40"},  64'(in_ready_w),  64'(e_rdy));
    chk({tag, ".out_valid40"}, 64'(out_valid_w), 64'(e_vld));
    chk({tag, ".busy40"},      64'(busy_w),      64'(e_busy));
    chk({tag, ".in_ready32"},  64'(in_ready_n),  64'(e_rdy));
    chk({tag, ".out_valid32"}, 64'(out_valid_n), 64'(e_vld));
    chk({tag, ".busy32"},      64'(busy_n),      64'(e_busy));
  endtask

  task automatic chk_res(input string tag, input longint unsigned sum);
    chk({tag, ".acc40"}, 64'(out_acc_w), sum & M40);
    chk({tag, ".ovf40"}, 64'(ovf_w),     64'(sum > M40));
    chk({tag, ".acc32"}, 64'(out_acc_n), sum & M32);
    chk({tag, ".ovf32"}, 64'(ovf_n),     64'(sum > M32));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run of n pairs from pa/pb. mode: 0 back-to-back, 1 alternate, 2 random gaps.
  // hold: cycles out_ready stays low in DONE. poke: pulse start mid-run.
  // rst_at: assert reset after that many accepts (-1 = never).
  task automatic do_run(input int n, input int mode, input int hold, input bit poke, input int rst_at);
    longint unsigned sum;
    int idx;
    int cyc;
    bit v;
    sum = 0;
    idx = 0;
    cyc = 0;
    chk_ctl("pre_start", 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk_ctl("len0", 1'b0, 1'b1, 1'b1);
      chk_res("len0", 0);
    end else begin
      chk_ctl("started", 1'b1, 1'b0, 1'b1);
      chk_res("cleared", 0);
      while (idx < n && cyc < 300) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        in_valid = v;
        in_a     = v ? pa[idx] : 16'($urandom);
        in_b     = v ? pb[idx] : 16'($urandom);
        if (poke && idx == 1) begin
          start = 1'b1;
          len   = 16'($urandom_range(1, 200));
        end else begin
          start = 1'b0;
        end
        tick();
        if (v) begin
          sum += 64'(pa[idx]) * 64'(pb[idx]);
          idx++;
        end
        cyc++;
        if (idx == rst_at) begin
          rst_n    = 1'b0;
          #1;
          in_valid = 1'b0;
          start    = 1'b0;
          chk_ctl("mid_rst", 1'b0, 1'b0, 1'b0);
          chk_res("mid_rst", 0);
          tick();
          rst_n = 1'b1;
          for (int i = 0; i < 5; i++) begin
            tick();
            chk_ctl("post_rst", 1'b0, 1'b0, 1'b0);
          end
          return;
        end
        if (idx < n) chk_ctl("accum", 1'b1, 1'b0, 1'b1);
      end
      start = 1'b0;
      if (idx < n) chk("accept_timeout", 64'(idx), 64'(n));
      // Offered pairs after the last accept must be ignored
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      chk_ctl("last_acc", 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("drain1", 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("drain2", 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("done", 1'b0, 1'b1, 1'b1);
      chk_res("done", sum);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      tick();
      chk_ctl("hold", 1'b0, 1'b1, 1'b1);
      chk_res("hold", sum);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_ctl("consumed", 1'b0, 1'b0, 1'b0);
    chk("ovf_idle40", 64'(ovf_w), 64'(sum > M40));
    chk("ovf_idle32", 64'(ovf_n), 64'(sum > M32));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_res("reset", 0);
    rst_n = 1'b1;
    tick();

    // Basic run: 3*4 + 5*6 + 7*8 = 98
    pa[0] = 16'd3; pb[0] = 16'd4;
    pa[1] = 16'd5; pb[1] = 16'd6;
    pa[2] = 16'd7; pb[2] = 16'd8;
    do_run(3, 0, 0, 1'b0, -1);

    // Largest single product
    pa[0] = 16'hFFFF; pb[0] = 16'hFFFF;
    do_run(1, 0, 0, 1'b0, -1);

    // Two largest products: wraps the 32-bit accumulator only
    pa[1] = 16'hFFFF; pb[1] = 16'hFFFF;
    do_run(2, 0, 1, 1'b0, -1);

    // Bubbles plus a held-off consumer
    for (int i = 0; i < 4; i++) begin
      pa[i] = 16'd2; pb[i] = 16'd2;
    end
    do_run(4, 1, 5, 1'b0, -1);

    // Empty run
    do_run(0, 0, 2, 1'b0, -1);

    // Start pulsed mid-run is ignored
    for (int i = 0; i < 5; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom);
    end
    do_run(5, 0, 0, 1'b1, -1);

    // Reset after 2 of 5, then a clean run
    do_run(5, 0, 0, 1'b0, 2);
    pa[0] = 16'd10; pb[0] = 16'd10;
    do_run(1, 0, 0, 1'b0, -1);

    // Randomized runs with large-biased operands
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        pa[i] = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFF - $urandom_range(0, 255)) : 16'($urandom);
        pb[i] = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFF - $urandom_range(0, 255)) : 16'($urandom);
      end
      do_run(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
